// File: rtl/timing_loop_ctrl_if.sv
// Port bundle between the timing-loop controller (slave) and the sample/error-detector side (master).
interface timing_loop_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NCO_WIDTH  = 24,
  parameter int MU_WIDTH   = 16
);
  logic                  sample_valid;
  logic                  err_valid;
  logic [DATA_WIDTH-1:0] e_k;
  logic                  strobe;
  logic [MU_WIDTH-1:0]   mu;
  logic                  locked;
  logic [NCO_WIDTH-1:0]  v_out;

  modport master (
    output sample_valid, err_valid, e_k,
    input  strobe, mu, locked, v_out
  );

  modport slave (
    input  sample_valid, err_valid, e_k,
    output strobe, mu, locked, v_out
  );
endinterface

// File: rtl/timing_loop_ctrl.sv
// Symbol-timing recovery loop: PI loop filter steering a modulo-1 NCO that issues interpolation strobes and mu.
// Define TLC_LOCK_DET_EN to add the ACQ/TRACK lock detector with gain switching; otherwise ACQ gains are fixed.
module timing_loop_ctrl #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NCO_WIDTH  = 24,
  parameter int                    MU_WIDTH   = 16,
  parameter int                    SPS_LOG2   = 1,
  parameter logic [NCO_WIDTH-1:0]  W_NOM      = 24'h800000,
  parameter int                    KP_ACQ_SH  = 4,
  parameter int                    KI_ACQ_SH  = 10
`ifdef TLC_LOCK_DET_EN
  ,
  parameter int                    KP_TRK_SH  = 6,
  parameter int                    KI_TRK_SH  = 14,
  parameter logic [DATA_WIDTH-1:0] LOCK_THR   = 16'h0400,
  parameter int                    LOCK_CNT   = 32,
  parameter int                    UNLOCK_CNT = 8
`endif
) (
  input logic               clk,
  input logic               rst,
  timing_loop_ctrl_if.slave bus
);

  localparam int EW = NCO_WIDTH + 2;
  localparam logic signed [EW-1:0] SAT_MAX = EW'({2'b00, W_NOM >> 1}) - EW'(1);
  localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX;

  function automatic logic signed [NCO_WIDTH-1:0] sat(input logic signed [EW-1:0] x);
    if (x > SAT_MAX) begin
      return SAT_MAX[NCO_WIDTH-1:0];
    end else if (x < SAT_MIN) begin
      return SAT_MIN[NCO_WIDTH-1:0];
    end else begin
      return x[NCO_WIDTH-1:0];
    end
  endfunction

  logic [NCO_WIDTH-1:0]        eta_q, eta_d;
  logic signed [NCO_WIDTH-1:0] integ_q, integ_d;
  logic signed [NCO_WIDTH-1:0] v_q, v_d;
  logic                        strobe_q, strobe_d;
  logic [MU_WIDTH-1:0]         mu_q, mu_d;

  logic signed [EW-1:0]        e_ext, p_term, i_term, integ_ext, integ_n_ext;
  logic [NCO_WIDTH-1:0]        w;

`ifdef TLC_LOCK_DET_EN
  typedef enum logic {ACQ, TRACK} state_t;
  localparam int CW = $clog2((LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         good_q, good_d, bad_q, bad_d;
  logic [CW-1:0]         good_inc, bad_inc;
  logic                  locked_q, locked_d;
  logic [DATA_WIDTH-1:0] abs_e;
  logic                  in_thr;
`endif

  // Error scaled so that full-scale e_k lines up with the NCO's 1.0; two guard bits absorb filter sums.
  always_comb begin
    e_ext = {{2{bus.e_k[DATA_WIDTH-1]}}, bus.e_k, {(NCO_WIDTH-DATA_WIDTH){1'b0}}};
`ifdef TLC_LOCK_DET_EN
    if (state_q == TRACK) begin
      p_term = e_ext >>> KP_TRK_SH;
      i_term = e_ext >>> KI_TRK_SH;
    end else begin
      p_term = e_ext >>> KP_ACQ_SH;
      i_term = e_ext >>> KI_ACQ_SH;
    end
`else
    p_term = e_ext >>> KP_ACQ_SH;
    i_term = e_ext >>> KI_ACQ_SH;
`endif
    integ_ext   = {{2{integ_q[NCO_WIDTH-1]}}, integ_q};
    integ_d     = integ_q;
    v_d         = v_q;
    integ_n_ext = integ_ext;
    if (bus.err_valid) begin
      integ_d     = sat(integ_ext + i_term);
      integ_n_ext = {{2{integ_d[NCO_WIDTH-1]}}, integ_d};
      v_d         = sat(p_term + integ_n_ext);
    end

    // NCO always steps with the registered v, so a same-cycle filter update lands one sample later.
    w        = W_NOM + v_q;
    eta_d    = eta_q;
    strobe_d = 1'b0;
    mu_d     = mu_q;
    if (bus.sample_valid) begin
      if (eta_q < w) begin
        strobe_d = 1'b1;
        mu_d     = eta_q[NCO_WIDTH-1-SPS_LOG2 -: MU_WIDTH];
      end
      eta_d = eta_q - w;
    end
  end

`ifdef TLC_LOCK_DET_EN
  // Magnitude of the most negative code is pinned to the most positive one.
  always_comb begin
    if (!bus.e_k[DATA_WIDTH-1]) begin
      abs_e = bus.e_k;
    end else if (bus.e_k == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
      abs_e = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      abs_e = ~bus.e_k + 1'b1;
    end
    in_thr   = (abs_e <= LOCK_THR);
    good_inc = good_q + 1'b1;
    bad_inc  = bad_q + 1'b1;
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    if (bus.err_valid) begin
      case (state_q)
        ACQ: begin
          if (!in_thr) begin
            good_d = '0;
          end else if (good_inc == CW'(LOCK_CNT)) begin
            state_d = TRACK;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end
        TRACK: begin
          if (in_thr) begin
            bad_d = '0;
          end else if (bad_inc == CW'(UNLOCK_CNT)) begin
            state_d = ACQ;
            bad_d   = '0;
          end else begin
            bad_d = bad_inc;
          end
        end
        default: state_d = ACQ;
      endcase
    end
    locked_d = (state_d == TRACK);
  end

  assign bus.locked = locked_q;
`else
  assign bus.locked = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eta_q    <= '1;
      integ_q  <= '0;
      v_q      <= '0;
      strobe_q <= 1'b0;
      mu_q     <= '0;
`ifdef TLC_LOCK_DET_EN
      state_q  <= ACQ;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
`endif
    end else begin
      eta_q    <= eta_d;
      integ_q  <= integ_d;
      v_q      <= v_d;
      strobe_q <= strobe_d;
      mu_q     <= mu_d;
`ifdef TLC_LOCK_DET_EN
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
`endif
    end
  end

  assign bus.strobe = strobe_q;
  assign bus.mu     = mu_q;
  assign bus.v_out  = v_q;

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Bench for timing_loop_ctrl: a cycle-level reference model pushes expected outputs to a queue,
// which is popped and compared one cycle later against the DUT.
module tb_timing_loop_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timing_loop_ctrl_if #(.DATA_WIDTH(16), .NCO_WIDTH(24), .MU_WIDTH(16)) bus ();

  timing_loop_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef TLC_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic        strobe;
    logic [15:0] mu;
    logic        locked;
    logic [23:0] v;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  longint mEta, mInteg, mV;
  int     mMu, goodCnt, badCnt;
  bit     mStrobe, mTrack;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic longint satm(input longint x);
    if (x > 64'sd4194303) return 64'sd4194303;
    if (x < -64'sd4194303) return -64'sd4194303;
    return x;
  endfunction

  task automatic modelReset();
    mEta = 64'sd16777215;
    mInteg = 0; mV = 0; mMu = 0;
    mStrobe = 1'b0; mTrack = 1'b0;
    goodCnt = 0; badCnt = 0;
  endtask

  // Reference behaviour for one clock; NCO is evaluated first so it sees the old v.
  task automatic modelStep(input bit sv, input bit ev, input logic [15:0] ek);
    longint w, eExt, ekS, mag;
    int kp, ki;
    bit inThr;
    exp_t e;
    w = 64'sd8388608 + mV;
    mStrobe = 1'b0;
    if (sv) begin
      if (mEta < w) begin
        mStrobe = 1'b1;
        mMu = int'(((mEta * 2) % 64'sd16777216) / 256);
      end
      mEta = mEta - w;
      if (mEta < 0) mEta = mEta + 64'sd16777216;
    end
    if (ev) begin
      ekS  = longint'($signed(ek));
      eExt = ekS * 256;
      if (LOCK_EN && mTrack) begin kp = 6; ki = 14; end
      else begin kp = 4; ki = 10; end
      mInteg = satm(mInteg + (eExt >>> ki));
      mV     = satm((eExt >>> kp) + mInteg);
      mag = (ekS < 0) ? -ekS : ekS;
      if (mag > 32767) mag = 32767;
      inThr = (mag <= 1024);
      if (LOCK_EN) begin
        if (!mTrack) begin
          if (inThr) begin
            goodCnt++;
            if (goodCnt == 32) begin mTrack = 1'b1; goodCnt = 0; end
          end else goodCnt = 0;
        end else begin
          if (!inThr) begin
            badCnt++;
            if (badCnt == 8) begin mTrack = 1'b0; badCnt = 0; end
          end else badCnt = 0;
        end
      end
    end
    e.strobe = mStrobe;
    e.mu     = mMu[15:0];
    e.locked = LOCK_EN ? mTrack : 1'b0;
    e.v      = mV[23:0];
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit sv, input bit ev, input logic [15:0] ek);
    exp_t e;
    bus.sample_valid = sv;
    bus.err_valid    = ev;
    bus.e_k          = ek;
    modelStep(sv, ev, ek);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("strobe", 32'(bus.strobe), 32'(e.strobe));
    checkOutput("mu",     32'(bus.mu),     32'(e.mu));
    checkOutput("locked", 32'(bus.locked), 32'(e.locked));
    checkOutput("v_out",  32'(bus.v_out),  32'(e.v));
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic asyncReset();
    bus.sample_valid = 1'b0;
    bus.err_valid    = 1'b0;
    bus.e_k          = '0;
    #2;
    rst = 1'b1;
    modelReset();
    expQ.delete();
    #1;
    checkOutput("rst_strobe", 32'(bus.strobe), 32'd0);
    checkOutput("rst_mu",     32'(bus.mu),     32'd0);
    checkOutput("rst_v_out",  32'(bus.v_out),  32'd0);
    checkOutput("rst_locked", 32'(bus.locked), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] ekTab [8];
    int guard;
    ekTab = '{16'h0000, 16'h0100, 16'hFF00, 16'h0400, 16'h0401, 16'hFC00, 16'h4000, 16'hC000};
    bus.sample_valid = 1'b0;
    bus.err_valid    = 1'b0;
    bus.e_k          = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_strobe", 32'(bus.strobe), 32'd0);
    checkOutput("init_mu",     32'(bus.mu),     32'd0);
    checkOutput("init_v_out",  32'(bus.v_out),  32'd0);
    checkOutput("init_locked", 32'(bus.locked), 32'd0);
    #2;
    rst = 1'b0;

    $display("[TB] free-running NCO, no error input");
    repeat (6) applyStimulus(1'b1, 1'b0, 16'h0000);

    $display("[TB] single error 0x0100 in ACQ");
    applyStimulus(1'b1, 1'b1, 16'h0100);
    checkOutput("v_single", 32'(bus.v_out), 32'h001040);
    repeat (12) applyStimulus(1'b1, 1'b0, 16'h0000);

    $display("[TB] lock acquisition");
    repeat (30) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h4000);
    checkOutput("lock_broken_run", 32'(bus.locked), 32'd0);
    repeat (31) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'h0000);
    checkOutput("lock_31", 32'(bus.locked), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    checkOutput("lock_32", 32'(bus.locked), 32'(LOCK_EN));

    $display("[TB] loss of lock");
    repeat (7) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'h4000);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    checkOutput("hold_after_7", 32'(bus.locked), 32'(LOCK_EN));
    repeat (7) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'h4000);
    checkOutput("unlock_7", 32'(bus.locked), 32'(LOCK_EN));
    applyStimulus(1'b1, 1'b1, 16'h4000);
    checkOutput("unlock_8", 32'(bus.locked), 32'd0);

    $display("[TB] most negative error counts as out of threshold");
    repeat (32) applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("relock", 32'(bus.locked), 32'(LOCK_EN));
    repeat (8) applyStimulus(1'b1, 1'b1, 16'h8000);
    checkOutput("unlock_8000", 32'(bus.locked), 32'd0);

    $display("[TB] filter saturation");
    repeat (600) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'h7FFF);
    checkOutput("v_sat_pos", 32'(bus.v_out), 32'h3FFFFF);
    repeat (1100) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'h8000);
    checkOutput("v_sat_neg", 32'(bus.v_out), 32'hC00001);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ekTab[$urandom_range(0, 7)]);
    end

    $display("[TB] asynchronous reset with strobe pending");
    guard = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 16'h0000);
      guard++;
    end while (!mStrobe && guard < 8);
    checkOutput("strobe_pending", 32'(mStrobe), 32'd1);
    asyncReset();
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("post_rst_s1", 32'(bus.strobe), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("post_rst_s2", 32'(bus.strobe), 32'd1);
    checkOutput("post_rst_mu", 32'(bus.mu), 32'hFFFF);
    repeat (4) applyStimulus(1'b1, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timing_loop_ctrl.md
# timing_loop_ctrl

Symbol-timing recovery controller that closes the loop around the zero-crossing timing-error detector and the interpolator. It filters the detector's timing error with a proportional-integral loop filter and drives a modulo-1 NCO. On each NCO underflow it issues an interpolation strobe and a fractional interval mu to the interpolator. A lock FSM switches loop gains between acquisition and tracking.

## Interface
- DATA_WIDTH, 16, width of e_k
- NCO_WIDTH, 24, NCO accumulator width; 2^NCO_WIDTH represents 1.0
- MU_WIDTH, 16, width of mu output
- SPS_LOG2, 1, log2 samples per symbol
- W_NOM, 24'h800000, nominal NCO step (1/SPS)
- KP_ACQ_SH, 4 / KI_ACQ_SH, 10, acquisition gain right-shifts
- KP_TRK_SH, 6 / KI_TRK_SH, 14, tracking gain right-shifts
- LOCK_THR, 16'h0400, |e_k| lock threshold
- LOCK_CNT, 32, consecutive in-threshold errors to declare lock
- UNLOCK_CNT, 8, consecutive out-of-threshold errors to drop lock
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- sample_valid  in  1  one input sample accepted this cycle; NCO steps once
- err_valid  in  1  e_k valid (from detector)
- e_k  in  DATA_WIDTH  signed timing error
- strobe  out  1  interpolant required; one-cycle pulse
- mu  out  MU_WIDTH  unsigned fractional interval, valid while strobe=1
- locked  out  1  loop in TRACK state
- v_out  out  NCO_WIDTH  signed loop-filter output (debug/monitor)

## Operation
- e_ext = e_k sign-extended to NCO_WIDTH+2 bits and multiplied by 2^(NCO_WIDTH-DATA_WIDTH).
- Gain shifts (KP_SH, KI_SH) are taken from the current state: ACQ uses the _ACQ pair; TRACK uses the _TRK pair.
- Loop filter (on err_valid):
  - integ_n = sat(integ + (e_ext >>> KI_SH)); integ <= integ_n.
  - v <= sat((e_ext >>> KP_SH) + integ_n).
  - sat clamps to the signed range ±(W_NOM/2 − 1).
  - Arithmetic shifts are used throughout.
- NCO (on sample_valid):
  - w = W_NOM + v, using the registered v from before any same-cycle update.
  - If eta < w, an underflow occurs:
    - strobe <= 1.
    - mu <= bits [NCO_WIDTH-1 -: MU_WIDTH] of (eta << SPS_LOG2) truncated to NCO_WIDTH, computed from the pre-decrement eta.
  - eta <= (eta − w) mod 2^NCO_WIDTH in all cases.
- Cycles without an underflow:
  - strobe <= 0.
  - mu holds its last value.
- Lock FSM, states ACQ (reset) and TRACK. Each err_valid compares |e_k| against LOCK_THR; |most negative e_k| saturates to the max positive value.
  - ACQ:
    - |e_k| ≤ LOCK_THR increments good_cnt; otherwise good_cnt clears.
    - When good_cnt reaches LOCK_CNT, go to TRACK and clear good_cnt.
  - TRACK:
    - |e_k| > LOCK_THR increments bad_cnt; otherwise bad_cnt clears.
    - When bad_cnt reaches UNLOCK_CNT, go to ACQ and clear bad_cnt.
  - integ and v are preserved across transitions.
- locked = (state == TRACK), registered.

## Timing
- Reset values:
  - eta = 2^NCO_WIDTH − 1.
  - integ, v, v_out, mu, strobe, locked, counters = 0.
  - state = ACQ.
- strobe and mu are asserted the cycle after the sample_valid that underflows. Latency is 1 cycle. strobe is never high two cycles unless sample_valid underflows on consecutive cycles.
- v is updated the cycle after err_valid. The new gains take effect for the first err_valid after the state change.
- Same-cycle err_valid and sample_valid: the NCO uses the old v; the filter updates normally.
- locked rises or falls one cycle after the err_valid that completes the count.
- err_valid without sample_valid, or the reverse, is legal; each path is independent.
- Asynchronous reset mid-operation immediately returns all state to reset values, with no strobe pulse.

## Configuration
- TLC_LOCK_DET_EN defined: the lock FSM and counters are present; gains switch as described.
- TLC_LOCK_DET_EN undefined: no FSM; ACQ gains are fixed; locked is tied 0.

## Test plan
- No err_valid, sample_valid every cycle (defaults):
  - sample 1: eta 0xFFFFFF→0x7FFFFF, no strobe.
  - sample 2: underflow; strobe=1 with mu=0xFFFF the next cycle; eta→0xFFFFFF.
  - Thereafter a strobe on every 2nd sample.
- Single err_valid with e_k=16'h0100 in ACQ:
  - integ=0x000040, v=0x001040, v_out matches the next cycle.
  - Following strobe spacing shortens accordingly.
- 32 consecutive err_valid with e_k=0 → locked=1 on the cycle after the 32nd. A 31-sample run followed by e_k=16'h4000 leaves locked=0.
- In TRACK:
  - 8 consecutive e_k=16'h4000 → locked=0 the next cycle.
  - 7 such errors then e_k=0 keeps locked=1.
- Saturation:
  - Repeated e_k=16'h7FFF clamps v to +0x3FFFFF and never exceeds it.
  - e_k=16'h8000 is treated as |e_k| = 0x7FFF.
- Assert rst mid-stream with strobe pending → all outputs 0 and eta=0xFFFFFF immediately. After release, the first strobe occurs on the 2nd sample.
